// File: rtl/coffee_pkg.sv
// Shared types and defaults for the coffee dispenser sequencer.
//   sched_state_e : scheduler FSM states
//   drink_t       : drink code at the default width
//   DEF_*         : default parameter values used by coffee_dispense_sched
package coffee_pkg;

  localparam int DEF_DRINK_W      = 3;
  localparam int DEF_TIMEOUT_CYC  = 1000;
  localparam int DEF_COOLDOWN_CYC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    COOL  = 2'd3
  } sched_state_e;

  typedef logic [DEF_DRINK_W-1:0] drink_t;

endpackage

// File: rtl/coffee_dispense_sched_rr_arbiter.sv
// Combinational round-robin picker.
//   req_valid  in  N_REQ : pending requests
//   ptr        in  IW    : highest-priority index for this pick (must be < N_REQ)
//   grant_any  out 1     : at least one request pending
//   grant_idx  out IW    : index of the winner (0 when grant_any=0)
//   grant_oh   out N_REQ : one-hot winner (all zero when grant_any=0)
// Winner is the first set req_valid scanning ptr, ptr+1, ... modulo N_REQ.
module rr_arbiter
  import coffee_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    ptr,
  output logic             grant_any,
  output logic [IW-1:0]    grant_idx,
  output logic [N_REQ-1:0] grant_oh
);

  // Candidate at scan offset gi is request (ptr + gi) mod N_REQ. One extra
  // bit on the sum keeps ptr + gi from wrapping before the modulo, which
  // matters when N_REQ is not a power of two.
  logic [IW-1:0]    cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_vld;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum          = {1'b0, ptr} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ))
                                                    : sum[IW-1:0];
      assign cand_vld[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the lowest offset (closest to ptr) wins.
  always_comb begin
    grant_any = |cand_vld;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        grant_idx = cand_idx[k];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oh
      assign grant_oh[gi] = grant_any && (grant_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/coffee_dispense_sched.sv
// Coffee dispenser sequencer: grants one order at a time round-robin,
// issues a one-cycle start plus drink code, waits for the dispenser's
// completion (with timeout), reports status and enforces a cooldown.
//   clk         in  1              : clock, rising edge
//   rst_n       in  1              : asynchronous active-low reset
//   req_valid   in  N_REQ          : per-front-end order pending
//   req_drink   in  N_REQ*DRINK_W  : per-front-end drink code, slice i = requester i
//   req_ready   out N_REQ          : one-hot pulse, order accepted
//   done_valid  out N_REQ          : one-hot pulse, order finished
//   done_err    out 1              : with done_valid, 1 = timeout abort
//   disp_start  out 1              : one-cycle dispense command
//   disp_drink  out DRINK_W        : drink code, held through WAIT
//   disp_done   in  1              : dispenser completion pulse
//   busy        out 1              : FSM not in IDLE
//   active_id   out clog2(N_REQ)   : current grant index
module coffee_dispense_sched
  import coffee_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DRINK_W      = DEF_DRINK_W,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DRINK_W-1:0]   req_drink,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           done_valid,
  output logic                       done_err,
  output logic                       disp_start,
  output logic [DRINK_W-1:0]         disp_drink,
  input  logic                       disp_done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   active_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(COOLDOWN_CYC + 1);

  sched_state_e       state_reg, state_next;
  logic [IW-1:0]      ptr_reg, ptr_next;
  logic [IW-1:0]      active_id_reg, active_id_next;
  logic [DRINK_W-1:0] disp_drink_reg, disp_drink_next;
  logic [TW-1:0]      to_cnt_reg, to_cnt_next;
  logic [CW-1:0]      cool_cnt_reg, cool_cnt_next;
  logic [N_REQ-1:0]   req_ready_reg, req_ready_next;
  logic [N_REQ-1:0]   done_valid_reg, done_valid_next;
  logic               done_err_reg, done_err_next;
  logic               disp_start_reg, disp_start_next;

  logic               grant_any;
  logic [IW-1:0]      grant_idx;
  logic [N_REQ-1:0]   grant_oh;
  logic [N_REQ-1:0]   active_oh;
  logic [DRINK_W-1:0] drink_arr [N_REQ];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .grant_any (grant_any),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign drink_arr[gi] = req_drink[gi*DRINK_W +: DRINK_W];
      assign active_oh[gi] = (active_id_reg == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      active_id_reg  <= '0;
      disp_drink_reg <= '0;
      to_cnt_reg     <= '0;
      cool_cnt_reg   <= '0;
      req_ready_reg  <= '0;
      done_valid_reg <= '0;
      done_err_reg   <= 1'b0;
      disp_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      active_id_reg  <= active_id_next;
      disp_drink_reg <= disp_drink_next;
      to_cnt_reg     <= to_cnt_next;
      cool_cnt_reg   <= cool_cnt_next;
      req_ready_reg  <= req_ready_next;
      done_valid_reg <= done_valid_next;
      done_err_reg   <= done_err_next;
      disp_start_reg <= disp_start_next;
    end
  end

  // The timeout counter is zero during START and advances on every edge from
  // there, so it reads k in the k-th WAIT cycle. Aborting on the edge where it
  // reads TIMEOUT_CYC-1 places the error pulse TIMEOUT_CYC cycles after START.
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    active_id_next  = active_id_reg;
    disp_drink_next = disp_drink_reg;
    to_cnt_next     = to_cnt_reg;
    cool_cnt_next   = cool_cnt_reg;
    req_ready_next  = '0;
    done_valid_next = '0;
    done_err_next   = 1'b0;
    disp_start_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          active_id_next  = grant_idx;
          disp_drink_next = drink_arr[grant_idx];
          ptr_next        = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
          to_cnt_next     = '0;
          req_ready_next  = grant_oh;
          disp_start_next = 1'b1;
          state_next      = START;
        end
      end

      START: begin
        to_cnt_next = to_cnt_reg + TW'(1);
        state_next  = WAIT;
      end

      WAIT: begin
        // A completion in the final WAIT cycle beats the abort.
        if (disp_done) begin
          done_valid_next = active_oh;
          done_err_next   = 1'b0;
          cool_cnt_next   = '0;
          state_next      = COOL;
        end else if (to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
          done_valid_next = active_oh;
          done_err_next   = 1'b1;
          cool_cnt_next   = '0;
          state_next      = COOL;
        end else begin
          to_cnt_next = to_cnt_reg + TW'(1);
        end
      end

      COOL: begin
        // disp_done is deliberately not looked at here: late callbacks vanish.
        if (cool_cnt_reg == CW'(COOLDOWN_CYC - 1)) begin
          state_next = IDLE;
        end else begin
          cool_cnt_next = cool_cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req_ready  = req_ready_reg;
  assign done_valid = done_valid_reg;
  assign done_err   = done_err_reg;
  assign disp_start = disp_start_reg;
  assign disp_drink = disp_drink_reg;
  assign active_id  = active_id_reg;
  assign busy       = (state_reg != IDLE);

endmodule
